// File: rtl/bbox_traverser_if.sv
// ---------------------------------------------------------------------------
// bbox_traverser_if
//   Groups the bounding-box input handshake, the pixel output handshake and
//   the flush/status lines of bbox_traverser into one bundle.
//   master : the surrounding environment (box producer, pixel consumer)
//   slave  : the traverser itself
// Signals
//   bb_valid/bb_ready       box handshake, box on top/bottom/left/right
//   top/bottom/left/right   half-open box: x in [left,right), y in [top,bottom)
//   flush                   abort the current box
//   pix_valid/pix_ready     pixel handshake, pixel on pix_x/pix_y/pix_last
//   busy, done              status: not idle / one-cycle end-of-box pulse
// ---------------------------------------------------------------------------
interface bbox_traverser_if #(
    parameter int WIDTH = 32
);
    logic             bb_valid;
    logic             bb_ready;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] bottom;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             flush;
    logic             pix_valid;
    logic             pix_ready;
    logic [WIDTH-1:0] pix_x;
    logic [WIDTH-1:0] pix_y;
    logic             pix_last;
    logic             busy;
    logic             done;

    modport master (
        output bb_valid, top, bottom, left, right, flush, pix_ready,
        input  bb_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
    );

    modport slave (
        input  bb_valid, top, bottom, left, right, flush, pix_ready,
        output bb_ready, pix_valid, pix_x, pix_y, pix_last, busy, done
    );
endinterface

// File: rtl/bbox_traverser.sv
// ---------------------------------------------------------------------------
// bbox_traverser
//   Walks every pixel of one triangle's bounding box and hands the
//   coordinates, one per accepted transfer, to the edge-function tester.
//   The box is half-open: x in [left,right), y in [top,bottom). Each box
//   ends with a one-cycle done pulse (also for an empty box); flush aborts
//   the box without a done pulse.
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset, beats everything incl. flush
//   bus   : bbox_traverser_if.slave (box in, pixels out, flush, busy, done)
// Build option
//   TRAVERSER_SERPENTINE_EN : when defined, rows alternate direction
//   (boustrophedon). When undefined the scan is plain raster order and the
//   direction logic does not exist.
// ---------------------------------------------------------------------------
module bbox_traverser #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    bbox_traverser_if.slave   bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    // Inclusive limits are stored (right-1, bottom-1) so no counter ever has
    // to reach right/bottom, which keeps boxes touching 2^WIDTH-1 from wrapping.
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] last_col_q, last_col_d;
    logic [WIDTH-1:0] last_row_q, last_row_d;
    logic             pix_valid_q, pix_valid_d;
    logic             pix_last_q, pix_last_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
`ifdef TRAVERSER_SERPENTINE_EN
    // 0: current row runs left->right-1, 1: right-1->left
    logic             dir_q, dir_d;
`endif

    logic             bb_ready_s;
    logic             accept_s;
    logic             box_empty_s;
    logic             hs_s;

    // Handshake decode; flush blocks acceptance in the same cycle.
    always_comb begin
        bb_ready_s  = (state_q == IDLE) && !bus.flush;
        accept_s    = bus.bb_valid && bb_ready_s;
        box_empty_s = (bus.left >= bus.right) || (bus.top >= bus.bottom);
        hs_s        = pix_valid_q && bus.pix_ready;
    end

    // Next-state and next-output logic for the IDLE/SCAN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        left_d      = left_q;
        last_col_d  = last_col_q;
        last_row_d  = last_row_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        done_d      = 1'b0;
`ifdef TRAVERSER_SERPENTINE_EN
        dir_d       = dir_q;
`endif

        if (bus.flush) begin
            // A pixel handshaking alongside flush counts as consumed; the
            // box is simply dropped with no done pulse.
            if (state_q != IDLE) begin
                state_d     = IDLE;
                pix_valid_d = 1'b0;
                pix_last_d  = 1'b0;
            end else begin
                state_d     = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        left_d     = bus.left;
                        last_col_d = bus.right - ONE;
                        last_row_d = bus.bottom - ONE;
`ifdef TRAVERSER_SERPENTINE_EN
                        dir_d      = 1'b0;
`endif
                        if (box_empty_s) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = SCAN;
                            pix_valid_d = 1'b1;
                            x_d         = bus.left;
                            y_d         = bus.top;
                            pix_last_d  = (bus.left == (bus.right - ONE)) &&
                                          (bus.top == (bus.bottom - ONE));
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end

                SCAN: begin
                    if (hs_s) begin
                        if (pix_last_q) begin
                            state_d     = DONE;
                            pix_valid_d = 1'b0;
                            pix_last_d  = 1'b0;
                            done_d      = 1'b1;
                        end else begin
`ifdef TRAVERSER_SERPENTINE_EN
                            // Row change happens at the row's end column;
                            // x stays put and the direction flips.
                            if (!dir_q) begin
                                if (x_q == last_col_q) begin
                                    y_d   = y_q + ONE;
                                    dir_d = 1'b1;
                                end else begin
                                    x_d   = x_q + ONE;
                                end
                            end else begin
                                if (x_q == left_q) begin
                                    y_d   = y_q + ONE;
                                    dir_d = 1'b0;
                                end else begin
                                    x_d   = x_q - ONE;
                                end
                            end
                            pix_last_d = (y_d == last_row_q) &&
                                         (x_d == (dir_d ? left_q : last_col_q));
`else
                            if (x_q == last_col_q) begin
                                x_d = left_q;
                                y_d = y_q + ONE;
                            end else begin
                                x_d = x_q + ONE;
                            end
                            pix_last_d = (x_d == last_col_q) && (y_d == last_row_q);
`endif
                        end
                    end else begin
                        state_d = SCAN;
                    end
                end

                DONE: begin
                    state_d = IDLE;
                end

                default: begin
                    state_d     = IDLE;
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            left_q      <= '0;
            last_col_q  <= '0;
            last_row_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
`ifdef TRAVERSER_SERPENTINE_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            left_q      <= left_d;
            last_col_q  <= last_col_d;
            last_row_q  <= last_row_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
`ifdef TRAVERSER_SERPENTINE_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign bus.bb_ready  = bb_ready_s;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_x     = x_q;
    assign bus.pix_y     = y_q;
    assign bus.pix_last  = pix_last_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bbox_traverser.sv
// ---------------------------------------------------------------------------
// tb_bbox_traverser
//   Table of boxes driven through the traverser; a reference enumerator pushes
//   the expected pixel stream into a scoreboard queue when a box is issued and
//   pixels are popped/compared as they handshake. Hand-written sequences cover
//   reset, mid-box reset, flush mid-box and flush while idle.
// ---------------------------------------------------------------------------
module tb_bbox_traverser;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bbox_traverser_if #(.WIDTH(W)) ifc ();

    bbox_traverser #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         last;
    } pix_t;

    typedef struct {
        logic [W-1:0] t;
        logic [W-1:0] b;
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           exp_pix;
        bit           stall;
    } vec_t;

    pix_t         sb_q[$];
    vec_t         vecs[8];
    int           n_total     = 0;
    int           n_pass      = 0;
    int           cyc_n       = 0;
    int           hs_cnt      = 0;
    int           last_hs_cyc = -10;
    bit           stalled_prev = 1'b0;
    bit           flush_prev   = 1'b0;
    logic [W-1:0] prev_x, prev_y;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc_n++;
    endtask

    // Reference enumeration of a box, pushed into the scoreboard.
    task automatic push_model(input logic [W-1:0] t, b, l, r);
        longint unsigned lt, lb, ll, lr, wd;
        pix_t p;
        lt = t; lb = b; ll = l; lr = r;
        if (ll >= lr || lt >= lb) return;
        wd = lr - ll;
        for (longint unsigned y = lt; y < lb; y++) begin
            for (longint unsigned i = 0; i < wd; i++) begin
                p.y = W'(y);
`ifdef TRAVERSER_SERPENTINE_EN
                p.x = (((y - lt) % 2) == 1) ? W'(lr - 1 - i) : W'(ll + i);
`else
                p.x = W'(ll + i);
`endif
                p.last = (y == lb - 1) && (i == wd - 1);
                sb_q.push_back(p);
            end
        end
    endtask

    // Called once per negedge, after pix_ready for the coming edge is set.
    task automatic mon();
        pix_t e;
        if (stalled_prev && !flush_prev) begin
            check("hold_valid", ifc.pix_valid, 1);
            check("hold_x", ifc.pix_x, prev_x);
            check("hold_y", ifc.pix_y, prev_y);
        end
        if (ifc.pix_valid && ifc.pix_ready) begin
            check("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pix_x", ifc.pix_x, e.x);
                check("pix_y", ifc.pix_y, e.y);
                check("pix_last", ifc.pix_last, e.last);
            end
            hs_cnt++;
            last_hs_cyc = cyc_n;
        end
        stalled_prev = ifc.pix_valid && !ifc.pix_ready;
        prev_x       = ifc.pix_x;
        prev_y       = ifc.pix_y;
        flush_prev   = ifc.flush;
    endtask

    task automatic run_vec(input vec_t v);
        int  a_cyc;
        bit  got_done;
        push_model(v.t, v.b, v.l, v.r);
        hs_cnt     = 0;
        ifc.top    = v.t;
        ifc.bottom = v.b;
        ifc.left   = v.l;
        ifc.right  = v.r;
        ifc.bb_valid  = 1'b1;
        ifc.pix_ready = 1'b1;
        check("bb_ready_idle", ifc.bb_ready, 1);
        a_cyc = cyc_n;
        tick();
        // Changing the box after acceptance must have no effect.
        ifc.bb_valid = 1'b0;
        ifc.top      = '0;
        ifc.bottom   = '1;
        ifc.left     = '0;
        ifc.right    = '1;
        check("busy_after_accept", ifc.busy, 1);
        check("bb_ready_busy", ifc.bb_ready, 0);
        if (v.exp_pix == 0) check("empty_no_valid", ifc.pix_valid, 0);
        else                check("first_pixel_latency", ifc.pix_valid, 1);
        got_done = 1'b0;
        for (int k = 0; k < 4 * v.exp_pix + 20; k++) begin
            if (v.stall) ifc.pix_ready = 1'($urandom_range(0, 1));
            mon();
            if (ifc.done) begin
                got_done = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", got_done, 1);
        check("pix_count", hs_cnt, v.exp_pix);
        check("sb_drained", sb_q.size(), 0);
        if (v.exp_pix > 0) check("done_after_last", cyc_n, last_hs_cyc + 1);
        else               check("done_after_empty", cyc_n, a_cyc + 1);
        ifc.pix_ready = 1'b1;
        tick();
        mon();
        check("done_one_cycle", ifc.done, 0);
        check("idle_busy", ifc.busy, 0);
        check("idle_bb_ready", ifc.bb_ready, 1);
        sb_q.delete();
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{32'd1, 32'd19, 32'd4, 32'd13, 162, 1'b0};
        vecs[1] = '{32'd1, 32'd19, 32'd4, 32'd13, 162, 1'b1};
        vecs[2] = '{32'd1, 32'd19, 32'd13, 32'd13, 0, 1'b0};
        vecs[3] = '{32'd5, 32'd5, 32'd0, 32'd10, 0, 1'b0};
        vecs[4] = '{32'd7, 32'd8, 32'd9, 32'd10, 1, 1'b1};
        vecs[5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 2, 1'b1};
        vecs[6] = '{32'd0, 32'd2, 32'd0, 32'd3, 6, 1'b1};
        vecs[7] = '{32'd20, 32'd10, 32'd0, 32'd5, 0, 1'b0};

        rst           = 1'b1;
        ifc.bb_valid  = 1'b0;
        ifc.top       = '0;
        ifc.bottom    = '0;
        ifc.left      = '0;
        ifc.right     = '0;
        ifc.flush     = 1'b0;
        ifc.pix_ready = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_pix_valid", ifc.pix_valid, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_done", ifc.done, 0);
        check("rst_pix_x", ifc.pix_x, 0);
        check("rst_pix_y", ifc.pix_y, 0);
        check("rst_pix_last", ifc.pix_last, 0);
        rst = 1'b0;
        tick();
        check("rst_bb_ready", ifc.bb_ready, 1);

        // Table of boxes.
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Flush mid-box, together with the 20th pixel handshake.
        push_model(32'd1, 32'd19, 32'd4, 32'd13);
        hs_cnt        = 0;
        ifc.top       = 32'd1;
        ifc.bottom    = 32'd19;
        ifc.left      = 32'd4;
        ifc.right     = 32'd13;
        ifc.bb_valid  = 1'b1;
        ifc.pix_ready = 1'b1;
        tick();
        ifc.bb_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            mon();
            if (hs_cnt == 20) break;
            tick();
        end
        check("flush_reached_20", hs_cnt, 20);
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        check("flush_pix_valid", ifc.pix_valid, 0);
        check("flush_busy", ifc.busy, 0);
        check("flush_no_done", ifc.done, 0);
        sb_q.delete();
        mon();
        for (int k = 0; k < 3; k++) begin
            tick();
            mon();
            check("post_flush_no_done", ifc.done, 0);
            check("post_flush_no_valid", ifc.pix_valid, 0);
        end

        // Flush while idle blocks acceptance.
        ifc.flush    = 1'b1;
        ifc.bb_valid = 1'b1;
        #1;
        check("flush_idle_bb_ready", ifc.bb_ready, 0);
        tick();
        ifc.bb_valid = 1'b0;
        ifc.flush    = 1'b0;
        check("flush_idle_not_accepted", ifc.busy, 0);
        tick();
        mon();

        v = '{32'd0, 32'd2, 32'd1918, 32'd1920, 4, 1'b0};
        run_vec(v);

        // Reset in the middle of a stalled box.
        ifc.top       = 32'd0;
        ifc.bottom    = 32'd4;
        ifc.left      = 32'd3;
        ifc.right     = 32'd7;
        ifc.bb_valid  = 1'b1;
        ifc.pix_ready = 1'b0;
        tick();
        ifc.bb_valid = 1'b0;
        check("pre_rst_valid", ifc.pix_valid, 1);
        tick();
        rst = 1'b1;
        ifc.flush = 1'b1;
        tick();
        rst = 1'b0;
        ifc.flush = 1'b0;
        stalled_prev = 1'b0;
        check("midbox_rst_valid", ifc.pix_valid, 0);
        check("midbox_rst_busy", ifc.busy, 0);
        check("midbox_rst_pix_x", ifc.pix_x, 0);
        tick();
        check("midbox_rst_bb_ready", ifc.bb_ready, 1);
        check("midbox_rst_done", ifc.done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
